mult_share_ctrl: RTL and testbench
==================================

// Module: mult_share_ctrl
// PURPOSE
//   Shares one sequential shift-add WIDTHxWIDTH multiplier between two requesters.
//   Arbitration is round-robin. Each requester uses a req/ack handshake.
//   Sits between operand sources (switch-loaded registers or other FSMs) and the
//   product display path (hex decoders, LEDR), replacing a combinational A*B.
// PARAMETERS
//   WIDTH  8  operand width; product is 2*WIDTH bits
// PORTS
//   Clock     in   1        single clock, rising-edge; the block's only clock
//   Reset     in   1        asynchronous, active-high reset
//   Req0      in   1        requester 0 wants a multiply; held until Ack0
//   A0,B0     in   WIDTH    requester 0 operands; sampled only at acceptance
//   Req1      in   1        requester 1 request
//   A1,B1     in   WIDTH    requester 1 operands
//   Ack0      out  1        one-cycle pulse: requester 0 result on Product
//   Ack1      out  1        one-cycle pulse: requester 1 result on Product
//   Busy      out  1        high in RUN and DONE
//   Owner     out  1        requester currently or last served
//   Product   out  2*WIDTH  last completed product; held until next completion
// BEHAVIOUR
//   Reset (async, any state, including mid-multiply):
//   - state=IDLE; Ack0=Ack1=Busy=0; Owner=0; Product=0.
//   - accumulator, multiplier and count registers = 0; last_owner=1, so
//     requester 0 wins the first tie.
//   - An aborted operation never produces an ack.
//   All outputs are registered; no combinational path from inputs to outputs.
//   FSM states are IDLE, RUN and DONE.
//   IDLE:
//   - At each edge, sample Req0/Req1.
//   - If neither is set, stay in IDLE.
//   - If exactly one is set, accept it.
//   - If both are set, accept the requester != last_owner.
//   - On acceptance: latch mcand={WIDTH'0,A}, mplier=B, acc=0, count=0;
//     Owner=last_owner=winner; Busy=1; go to RUN.
//   RUN (exactly WIDTH cycles):
//   - Each edge: if mplier[0], acc<=acc+mcand.
//   - Then mcand<<=1, mplier>>=1, count++.
//   - After the WIDTH-th step (count==WIDTH-1), Product<=final acc and go to DONE.
//   - acc is 2*WIDTH bits and never overflows; no truncation.
//   - Req/A/B changes during RUN are ignored, including the non-owner raising Req.
//   DONE (one cycle):
//   - Ack[Owner]=1 for exactly this cycle; Busy=1.
//   - Next edge: Ack=0, Busy=0, go to IDLE.
//   Latency:
//   - Accept at edge t0; Product updates and Ack rises at edge t0+WIDTH.
//   - Ack falls at t0+WIDTH+1, when state is back in IDLE.
//   - The earliest next acceptance is edge t0+WIDTH+2.
//   Handshake:
//   - A requester holds Req and stable operands until it sees Ack.
//   - It may drop Req at the edge ending the Ack cycle.
//   - If Req is still high in IDLE, that is a new request and is arbitrated normally.
//   - Fairness: under continuous dual requests, service strictly alternates.
//   Edge cases:
//   - A=0 or B=0 still takes the full WIDTH cycles and gives Product=0.
//   - Max case: (2^WIDTH-1)^2 = 0xFE01 for WIDTH=8.
// TESTING
//   1. Assert Reset mid-stream -> Product=0, Ack0=Ack1=Busy=Owner=0 immediately (async).
//   2. Req0=1, A0=0x0C, B0=0x0A -> accept edge t0; Product=0x0078 and Ack0=1 at t0+8;
//      Ack0 pulse exactly 1 cycle; Owner=0; Ack1 stays 0.
//   3. After reset, Req0 and Req1 rise together; A0=B0=0xFF, A1=0x00, B1=0x37
//      -> Ack0 first with Product=0xFE01, then Ack1 with Product=0x0000,
//      with Owner tracking each.
//   4. Req0 and Req1 both held high for 4 transactions -> acks alternate 1,0,1,0
//      (last served was 0 before the run); each accept is 10 cycles after the previous.
//   5. Req1, A1=0x03, B1=0x05; change A1 to 0xFF at RUN cycle 3 -> Product=0x000F.
//   6. Req0, A0=0x80, B0=0x80; Reset pulsed at RUN cycle 4 -> no Ack; Product stays 0;
//      after release, a held Req0 is re-accepted -> Product=0x4000.

Source files
------------

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: one sequential shift-add WIDTHxWIDTH multiplier shared by two
// requesters. Round-robin arbitration with a req/ack handshake per requester.
// An accepted operation takes WIDTH RUN cycles, then one DONE cycle that pulses
// the owner's ack while the product is already stable on o_product.
module mult_share_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req0,
    input  logic [WIDTH-1:0]   i_a0,
    input  logic [WIDTH-1:0]   i_b0,
    input  logic               i_req1,
    input  logic [WIDTH-1:0]   i_a1,
    input  logic [WIDTH-1:0]   i_b1,
    output logic               o_ack0,
    output logic               o_ack1,
    output logic               o_busy,
    output logic               o_owner,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CNT_W-1:0]     r_count;
    logic                 r_last_owner;
    logic                 r_owner;
    logic                 r_busy;
    logic                 r_ack0;
    logic                 r_ack1;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_accept;
    logic                 w_winner;
    logic                 w_last_step;
    logic [WIDTH-1:0]     w_a_sel;
    logic [WIDTH-1:0]     w_b_sel;
    logic [2*WIDTH-1:0]   w_sum;

    // Operand mux for the arbitration winner, and one shift-add step.
    assign w_a_sel = w_winner ? i_a1 : i_a0;
    assign w_b_sel = w_winner ? i_b1 : i_b0;
    assign w_sum   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and round-robin arbitration.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_winner     = r_last_owner;
        w_last_step  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req0 || i_req1) begin
                    w_accept     = 1'b1;
                    // On a tie the requester that was not served last wins.
                    w_winner     = (i_req0 && i_req1) ? ~r_last_owner : i_req1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (r_count == LAST_CNT) begin
                    w_last_step  = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    // NOTE: the datapath registers are small and reset along with the FSM so an
    // aborted multiply leaves no stale partial product behind.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_count      <= '0;
            r_last_owner <= 1'b1;
            r_owner      <= 1'b0;
            r_busy       <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_product    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand      <= {{WIDTH{1'b0}}, w_a_sel};
                        r_mplier     <= w_b_sel;
                        r_acc        <= '0;
                        r_count      <= '0;
                        r_owner      <= w_winner;
                        r_last_owner <= w_winner;
                        r_busy       <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CNT_W'(1);
                    if (w_last_step) begin
                        r_product <= w_sum;
                        r_ack0    <= ~r_owner;
                        r_ack1    <= r_owner;
                    end
                end
                S_DONE: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign o_ack0    = r_ack0;
    assign o_ack1    = r_ack1;
    assign o_busy    = r_busy;
    assign o_owner   = r_owner;
    assign o_product = r_product;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: scenario tasks plus randomized transactions checked against
// a reference model (arithmetic product, round-robin winner from last served).
module tb_mult_share_ctrl;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic          ack0, ack1, busy, owner;
    logic [PW-1:0] product;

    int   n_vec = 0;
    int   n_err = 0;
    logic model_last = 1'b1;

    mult_share_ctrl #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0(req0), .i_a0(a0), .i_b0(b0),
        .i_req1(req1), .i_a1(a1), .i_b1(b1),
        .o_ack0(ack0), .o_ack1(ack1), .o_busy(busy),
        .o_owner(owner), .o_product(product)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: winner is the only requester, or on a tie the one not served last.
    function automatic logic pick(input logic r0, input logic r1);
        if (r0 && r1) return !model_last;
        return r1;
    endfunction

    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        return PW'(a) * PW'(b);
    endfunction

    function automatic logic [W-1:0] rand_op();
        int unsigned s;
        s = $urandom_range(0, 5);
        if (s == 0) return '0;
        if (s == 1) return '1;
        return W'($urandom);
    endfunction

    // Advance negedge by negedge until an ack is seen or the budget runs out.
    task automatic wait_ack(input int budget, output int cyc, output logic g0, output logic g1);
        cyc = 0; g0 = 1'b0; g1 = 1'b0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ack0 || ack1) begin
                g0 = ack0; g1 = ack1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        req0 = 1'b0; req1 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if ({ack0, ack1, busy, owner, product} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ack0=%b ack1=%b busy=%b owner=%b product=%h, expected all 0", ack0, ack1, busy, owner, product);
        end
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
    endtask

    task automatic test_single();
        int cyc; logic g0, g1;
        req0 = 1'b1; a0 = 8'h0C; b0 = 8'h0A;
        @(negedge clk);
        n_vec++;
        if ({busy, owner, ack0, ack1} !== 4'b1000) begin
            n_err++;
            $display("FAIL single_accept: got busy/owner/ack0/ack1=%b, expected 1000", {busy, owner, ack0, ack1});
        end
        wait_ack(W + 4, cyc, g0, g1);
        n_vec++;
        if (cyc !== W || {g0, g1} !== 2'b10) begin
            n_err++;
            $display("FAIL single_latency: got cyc=%0d acks=%b, expected cyc=%0d acks=10", cyc, {g0, g1}, W);
        end
        n_vec++;
        if (product !== 16'h0078 || owner !== 1'b0) begin
            n_err++;
            $display("FAIL single_product: got %h owner=%b, expected 0078 owner=0", product, owner);
        end
        req0 = 1'b0;
        model_last = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({ack0, ack1, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL single_pulse_width: got ack0/ack1/busy=%b, expected 000", {ack0, ack1, busy});
        end
    endtask

    task automatic test_tie();
        int cyc; logic g0, g1;
        apply_reset();
        req0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF;
        req1 = 1'b1; a1 = 8'h00; b1 = 8'h37;
        wait_ack(W + 6, cyc, g0, g1);
        n_vec++;
        if (cyc !== W + 1 || {g0, g1} !== 2'b10 || product !== 16'hFE01 || owner !== 1'b0) begin
            n_err++;
            $display("FAIL tie_first: got cyc=%0d acks=%b product=%h owner=%b, expected cyc=%0d acks=10 product=fe01 owner=0", cyc, {g0, g1}, product, owner, W + 1);
        end
        req0 = 1'b0;
        model_last = 1'b0;
        wait_ack(W + 6, cyc, g0, g1);
        n_vec++;
        if (cyc !== W + 2 || {g0, g1} !== 2'b01 || product !== 16'h0000 || owner !== 1'b1) begin
            n_err++;
            $display("FAIL tie_second: got cyc=%0d acks=%b product=%h owner=%b, expected cyc=%0d acks=01 product=0000 owner=1", cyc, {g0, g1}, product, owner, W + 2);
        end
        req1 = 1'b0;
        model_last = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int cyc; logic g0, g1; logic exp_w; logic [PW-1:0] exp_p;
        req0 = 1'b1; a0 = rand_op(); b0 = rand_op();
        exp_p = ref_mul(a0, b0);
        wait_ack(W + 6, cyc, g0, g1);
        n_vec++;
        if ({g0, g1} !== 2'b10 || product !== exp_p) begin
            n_err++;
            $display("FAIL fair_prologue: got acks=%b product=%h, expected acks=10 product=%h", {g0, g1}, product, exp_p);
        end
        model_last = 1'b0;
        req1 = 1'b1; a1 = rand_op(); b1 = rand_op();
        a0 = rand_op(); b0 = rand_op();
        for (int i = 0; i < 4; i++) begin
            exp_w = pick(1'b1, 1'b1);
            exp_p = exp_w ? ref_mul(a1, b1) : ref_mul(a0, b0);
            wait_ack(W + 6, cyc, g0, g1);
            n_vec++;
            if (cyc !== W + 2 || g1 !== exp_w || g0 !== !exp_w || owner !== exp_w || product !== exp_p) begin
                n_err++;
                $display("FAIL fair_txn%0d: got cyc=%0d acks=%b owner=%b product=%h, expected cyc=%0d owner=%b product=%h", i, cyc, {g0, g1}, owner, product, W + 2, exp_w, exp_p);
            end
            model_last = exp_w;
            if (exp_w) begin a1 = rand_op(); b1 = rand_op(); end
            else       begin a0 = rand_op(); b0 = rand_op(); end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_operand_change();
        int cyc; logic g0, g1; logic [PW-1:0] exp_p;
        req1 = 1'b1; a1 = 8'h03; b1 = 8'h05;
        repeat (3) @(negedge clk);
        a1 = 8'hFF; b1 = rand_op();
        req0 = 1'b1; a0 = rand_op(); b0 = rand_op();
        wait_ack(W + 4, cyc, g0, g1);
        n_vec++;
        if (cyc !== W - 2 || {g0, g1} !== 2'b01 || product !== 16'h000F || owner !== 1'b1) begin
            n_err++;
            $display("FAIL opchg_product: got cyc=%0d acks=%b product=%h owner=%b, expected cyc=%0d acks=01 product=000f owner=1", cyc, {g0, g1}, product, owner, W - 2);
        end
        model_last = 1'b1;
        req1 = 1'b0;
        exp_p = ref_mul(a0, b0);
        wait_ack(W + 6, cyc, g0, g1);
        n_vec++;
        if (cyc !== W + 2 || {g0, g1} !== 2'b10 || product !== exp_p || owner !== 1'b0) begin
            n_err++;
            $display("FAIL opchg_deferred_req0: got cyc=%0d acks=%b product=%h owner=%b, expected cyc=%0d acks=10 product=%h owner=0", cyc, {g0, g1}, product, owner, W + 2, exp_p);
        end
        model_last = 1'b0;
        req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int cyc; logic g0, g1;
        req0 = 1'b1; a0 = 8'h80; b0 = 8'h80;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({ack0, ack1, busy, owner, product} !== '0) begin
            n_err++;
            $display("FAIL abort_async_reset: got ack0=%b ack1=%b busy=%b owner=%b product=%h, expected all 0", ack0, ack1, busy, owner, product);
        end
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if ({ack0, ack1, busy, product} !== '0) begin
            n_err++;
            $display("FAIL abort_held_reset: got ack0=%b ack1=%b busy=%b product=%h, expected all 0", ack0, ack1, busy, product);
        end
        rst = 1'b0;
        model_last = 1'b1;
        wait_ack(W + 6, cyc, g0, g1);
        n_vec++;
        if (cyc !== W + 1 || {g0, g1} !== 2'b10 || product !== 16'h4000 || owner !== 1'b0) begin
            n_err++;
            $display("FAIL abort_reaccept: got cyc=%0d acks=%b product=%h owner=%b, expected cyc=%0d acks=10 product=4000 owner=0", cyc, {g0, g1}, product, owner, W + 1);
        end
        model_last = 1'b0;
        req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int cyc; logic g0, g1; logic exp_w; logic [PW-1:0] exp_p; logic [1:0] r;
        for (int i = 0; i < 24; i++) begin
            r = 2'($urandom_range(1, 3));
            req0 = r[0]; req1 = r[1];
            a0 = rand_op(); b0 = rand_op(); a1 = rand_op(); b1 = rand_op();
            exp_w = pick(req0, req1);
            exp_p = exp_w ? ref_mul(a1, b1) : ref_mul(a0, b0);
            wait_ack(W + 6, cyc, g0, g1);
            n_vec++;
            if (cyc !== W + 1 || g1 !== exp_w || g0 !== !exp_w || owner !== exp_w || busy !== 1'b1 || product !== exp_p) begin
                n_err++;
                $display("FAIL random_txn%0d: got cyc=%0d acks=%b owner=%b busy=%b product=%h, expected cyc=%0d owner=%b busy=1 product=%h", i, cyc, {g0, g1}, owner, busy, product, W + 1, exp_w, exp_p);
            end
            model_last = exp_w;
            req0 = 1'b0; req1 = 1'b0;
            @(negedge clk);
            n_vec++;
            if ({ack0, ack1, busy} !== 3'b000 || product !== exp_p) begin
                n_err++;
                $display("FAIL random_idle%0d: got ack0/ack1/busy=%b product=%h, expected 000 product=%h", i, {ack0, ack1, busy}, product, exp_p);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_operand_change();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
